// File: rtl/fp_div_sig_iter.sv
// Iterative restoring significand divider for the fp_div datapath.
// It produces one quotient bit per enabled cycle and presents the normalised
// quotient, the guard/round/sticky bits and the count flag with a
// valid/ready handshake on each side.
module fp_div_sig_iter #(
  parameter int sig_width = 23
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [sig_width:0] x,
  input  logic [sig_width:0] d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [sig_width:0] quotient,
  output logic               guard_bit,
  output logic               round_bit,
  output logic               sticky_bit,
  output logic               count,
  output logic               busy
);

  localparam int N  = sig_width + 3;
  localparam int W  = sig_width + 2;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [W-1:0]       rem;
  logic [W-1:0]       rem_sub;
  logic [W-1:0]       rem_shift;
  logic [W-1:0]       d_ext;
  logic [W-1:0]       rem_load;
  logic [sig_width:0] d_reg;
  logic [N-1:0]       q_sr;
  logic [N-1:0]       q_next;
  logic [CW-1:0]      iter;
  logic               cnt;
  logic               x_lt_d;
  logic               qbit;
  logic               last_iter;
  logic               accept;

  // One restoring step: trial subtract, keep it if it does not underflow, then shift.
  always_comb begin
    d_ext     = {1'b0, d_reg};
    qbit      = (rem >= d_ext);
    rem_sub   = qbit ? (rem - d_ext) : rem;
    rem_shift = {rem_sub[W-2:0], 1'b0};
    q_next    = {q_sr[N-2:0], qbit};
    last_iter = (iter == CW'(N - 1));
    x_lt_d    = (x < d);
    rem_load  = x_lt_d ? {x, 1'b0} : {1'b0, x};
  end

  // Next-state and handshake outputs; ready in DONE follows the consumer so a new operand can hand off on the same edge.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (enable && in_valid) state_next = CALC;
      end
      CALC: begin
        if (enable && last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (enable && out_ready) state_next = in_valid ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = enable && in_valid && in_ready;

  // State register; a low enable freezes the FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else if (enable) begin
      state <= state_next;
    end
  end

  // Datapath: operand load, iteration, and capture of the finished result on the last step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem        <= '0;
      d_reg      <= '0;
      q_sr       <= '0;
      iter       <= '0;
      cnt        <= 1'b0;
      quotient   <= '0;
      guard_bit  <= 1'b0;
      round_bit  <= 1'b0;
      sticky_bit <= 1'b0;
      count      <= 1'b0;
    end else if (enable) begin
      if (accept) begin
        rem   <= rem_load;
        d_reg <= d;
        cnt   <= x_lt_d;
        q_sr  <= '0;
        iter  <= '0;
      end else if (state == CALC) begin
        rem  <= rem_shift;
        q_sr <= q_next;
        iter <= iter + 1'b1;
        if (last_iter) begin
          quotient   <= q_next[N-1:2];
          guard_bit  <= q_next[1];
          round_bit  <= q_next[0];
          sticky_bit <= (rem_shift != '0);
          count      <= cnt;
        end
      end
    end
  end

endmodule
